ahb_txn_sequencer: RTL and testbench

Sequencer and arbiter that shares the single AHB master port of the AHB-to-APB bridge testbed between NUM_REQ requesters. It accepts one single-beat read or write per handshake, chooses among requesters round-robin, and drives a NONSEQ address phase followed by a data phase on the bridge's AHB slave side. It waits on Hreadyout, captures Hrdata and Hresp, and returns a one-cycle response to the granted requester. A wait-state watchdog aborts hung transfers.

---
 rtl/ahb_seq_pkg.sv | 29 ++
 rtl/ahb_rr_arbiter.sv | 42 ++++
 rtl/ahb_txn_sequencer.sv | 137 +++++++++++++
 tb/tb_ahb_txn_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_seq_pkg.sv
// Shared types for the AHB transaction sequencer: bus encodings and sequencer FSM states.
package ahb_seq_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  // Anything other than OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != HRESP_OKAY;
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, search starting after the last granted index.
module ahb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Reset points at the highest index so requester 0 is searched first.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (update) begin
      last_grant <= grant_idx;
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_txn_sequencer.sv
// Shares one AHB master port between NUM_REQ requesters: round-robin grant, single NONSEQ
// transfers, wait-state watchdog, and a one-cycle response pulse to the granted requester.
module ahb_txn_sequencer
  import ahb_seq_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  input  logic                      Hreadyout,
  input  logic [1:0]                Hresp,
  input  logic [DATA_W-1:0]         Hrdata,
  output logic                      Hwrite,
  output logic                      Hreadyin,
  output logic [1:0]                Htrans,
  output logic [ADDR_W-1:0]         Haddr,
  output logic [DATA_W-1:0]         Hwdata,
  output state_t                    dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t             state_q;
  state_t             state_n;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   grant_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               sticky_err;
  logic               handshake;
  logic               timeout;
  logic               done;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_write;

  ahb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .req       (req_valid),
    .update    (handshake),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign dbg_state = state_q;
  assign req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
  assign handshake = |(req_valid & req_ready);
  assign timeout   = (state_q == ST_DATA) && !Hreadyout && (wait_cnt == CNT_W'(WAIT_MAX));
  assign done      = (state_q == ST_DATA) && (Hreadyout || timeout);

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_IDLE: if (handshake) state_n = ST_ADDR;
      ST_ADDR: if (Hreadyout) state_n = ST_DATA;
      ST_DATA: if (done)      state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      sticky_err <= 1'b0;
      Htrans     <= HTRANS_IDLE;
      Hwrite     <= 1'b0;
      Haddr      <= '0;
      Hwdata     <= '0;
      Hreadyin   <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q   <= state_n;
      Hreadyin  <= 1'b1;
      Htrans    <= (state_n == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      rsp_valid <= '0;

      if (handshake) begin
        Haddr   <= sel_addr;
        Hwrite  <= sel_write;
        wdata_q <= sel_wdata;
        grant_q <= arb_idx;
      end

      // Write data is presented from the first data-phase cycle onwards.
      if (state_q == ST_ADDR && Hreadyout) begin
        Hwdata <= Hwrite ? wdata_q : '0;
      end

      if (state_q == ST_DATA) begin
        if (done) begin
          rsp_valid[grant_q] <= 1'b1;
          rsp_rdata          <= (timeout || Hwrite) ? '0 : Hrdata;
          rsp_err            <= timeout || resp_is_err(Hresp) || sticky_err;
          wait_cnt           <= '0;
          sticky_err         <= 1'b0;
        end else begin
          // An ERROR seen in the first of its two cycles must survive to completion.
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (resp_is_err(Hresp)) sticky_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_txn_sequencer.sv
// Self-checking bench for ahb_txn_sequencer: cycle-stepped bridge driver plus response scoreboard.
module tb_ahb_txn_sequencer;
  import ahb_seq_pkg::*;

  localparam int NUM_REQ  = 2;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WAIT_MAX = 4;

  logic                      Hclk;
  logic                      Hreset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      Hreadyout;
  logic [1:0]                Hresp;
  logic [DATA_W-1:0]         Hrdata;
  logic                      Hwrite;
  logic                      Hreadyin;
  logic [1:0]                Htrans;
  logic [ADDR_W-1:0]         Haddr;
  logic [DATA_W-1:0]         Hwdata;
  state_t                    dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int multi_hot = 0;
  logic [34:0] exp_q[$];

  ahb_txn_sequencer #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
    .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every response pulse is compared against the oldest expectation.
  always @(negedge Hclk) begin
    if (rsp_valid !== '0) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      else check("rsp_data", {rsp_valid, rsp_err, rsp_rdata}, exp_q.pop_front());
    end
    if ($countones(req_ready) > 1) multi_hot++;
  end

  // Drives one transfer from an IDLE negedge through to the response cycle.
  task automatic run_txn(input int r, input logic [1:0] vmask, input logic hold,
                         input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int aw, input int dw, input logic [1:0] wresp,
                         input logic [1:0] fresp, input logic [31:0] rdata, input logic stuck);
    logic [1:0]  oh;
    logic        err_e;
    logic [31:0] rd_e;
    oh = 2'b01 << r;
    req_write[r] = wr;
    req_addr[r*ADDR_W +: ADDR_W] = addr;
    req_wdata[r*DATA_W +: DATA_W] = wdata;
    req_valid = vmask | oh;
    Hreadyout = 1'b1;
    Hresp = 2'b00;
    err_e = stuck || (fresp != 2'b00) || (dw > 0 && wresp != 2'b00);
    rd_e  = (wr || stuck) ? 32'd0 : rdata;
    #1;
    check("req_ready", req_ready, oh);
    exp_q.push_back({oh, err_e, rd_e});
    @(negedge Hclk);
    if (!hold) req_valid = '0;
    check("htrans_addr", Htrans, 2'b10);
    check("haddr", Haddr, addr);
    check("hwrite", Hwrite, wr);
    for (int i = 0; i < aw; i++) begin
      Hreadyout = 1'b0;
      @(negedge Hclk);
      check("htrans_addr_wait", Htrans, 2'b10);
    end
    Hreadyout = 1'b1;
    @(negedge Hclk);
    check("htrans_data", Htrans, 2'b00);
    if (wr) check("hwdata", Hwdata, wdata);
    if (stuck) begin
      Hrdata = 32'hDEAD_BEEF;
      for (int i = 0; i < WAIT_MAX + 1; i++) begin
        Hreadyout = 1'b0;
        @(negedge Hclk);
      end
      check("timeout_state", dbg_state, ST_IDLE);
    end else begin
      for (int i = 0; i < dw; i++) begin
        Hreadyout = 1'b0;
        Hresp = wresp;
        @(negedge Hclk);
      end
      Hreadyout = 1'b1;
      Hresp = fresp;
      Hrdata = rdata;
      @(negedge Hclk);
    end
    check("rsp_latency", rsp_valid, oh);
    Hreadyout = 1'b1;
    Hresp = 2'b00;
  endtask

  task automatic check_reset_outputs(input logic exp_hreadyin);
    check("rst_htrans", Htrans, 2'b00);
    check("rst_hwrite", Hwrite, 1'b0);
    check("rst_haddr", Haddr, 32'd0);
    check("rst_hwdata", Hwdata, 32'd0);
    check("rst_hreadyin", Hreadyin, exp_hreadyin);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("rst_state", dbg_state, ST_IDLE);
  endtask

  initial begin
    Hreset = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    Hreadyout = 1'b1;
    Hresp = 2'b00;
    Hrdata = '0;
    repeat (3) @(negedge Hclk);
    check_reset_outputs(1'b0);
    Hreset = 1'b0;
    @(negedge Hclk);
    check("hreadyin_run", Hreadyin, 1'b1);

    // Zero-wait write, then read with three data wait states
    run_txn(0, 2'b00, 1'b0, 1'b1, 32'h8000_0001, 32'h0000_00A3, 0, 0, 2'b00, 2'b00, 32'd0, 1'b0);
    run_txn(1, 2'b00, 1'b0, 1'b0, 32'h8000_00A2, 32'd0, 0, 3, 2'b00, 2'b00, 32'h5A5A_1234, 1'b0);

    // Reset coinciding with a request: nothing latched
    Hreset = 1'b1;
    req_valid = 2'b01;
    req_addr[31:0] = 32'h1234_5678;
    @(negedge Hclk);
    check("rst_hs_state", dbg_state, ST_IDLE);
    check("rst_hs_haddr", Haddr, 32'd0);
    Hreset = 1'b0;

    // Both requesters held high from reset: grants alternate 0,1,0,1
    run_txn(0, 2'b11, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_0000, 0, 0, 2'b00, 2'b00, 32'd0, 1'b0);
    run_txn(1, 2'b11, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 2, 0, 2'b00, 2'b00, 32'hCAFE_0001, 1'b0);
    run_txn(0, 2'b11, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 0, 1, 2'b00, 2'b00, 32'hCAFE_0002, 1'b0);
    run_txn(1, 2'b11, 1'b0, 1'b1, 32'h0000_0400, 32'h2222_0000, 0, 0, 2'b00, 2'b00, 32'd0, 1'b0);

    // Two-cycle ERROR, wait-cycle-only error, then a clean OKAY
    run_txn(0, 2'b00, 1'b0, 1'b0, 32'h0000_0500, 32'd0, 0, 1, 2'b01, 2'b01, 32'h0BAD_0001, 1'b0);
    run_txn(1, 2'b00, 1'b0, 1'b0, 32'h0000_0600, 32'd0, 0, 2, 2'b01, 2'b00, 32'h0BAD_0002, 1'b0);
    run_txn(1, 2'b00, 1'b0, 1'b1, 32'h0000_0700, 32'h3333_0000, 0, 0, 2'b00, 2'b00, 32'd0, 1'b0);

    // Watchdog abort, then the next request is still accepted
    run_txn(1, 2'b00, 1'b0, 1'b0, 32'h0000_0800, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 1'b1);
    run_txn(0, 2'b00, 1'b0, 1'b1, 32'h0000_0900, 32'h0000_0077, 0, 0, 2'b00, 2'b00, 32'd0, 1'b0);

    // Randomised single-requester transfers
    for (int k = 0; k < 8; k++) begin
      int r;
      logic wr;
      r = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      run_txn(r, 2'b00, 1'b0, wr, $urandom, $urandom, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom, 1'b0);
    end

    // Reset during ADDR after granting requester 0: transfer dropped, req0 priority restored
    run_txn(0, 2'b00, 1'b0, 1'b1, 32'h0000_0A00, 32'h0000_0055, 0, 0, 2'b00, 2'b00, 32'd0, 1'b0);
    req_write[0] = 1'b1;
    req_addr[31:0] = 32'h8000_0010;
    req_wdata[31:0] = 32'h0000_0099;
    req_valid = 2'b01;
    @(negedge Hclk);
    check("pre_rst_htrans", Htrans, 2'b10);
    req_valid = '0;
    Hreset = 1'b1;
    @(negedge Hclk);
    check_reset_outputs(1'b0);
    Hreset = 1'b0;
    repeat (2) @(negedge Hclk);
    run_txn(0, 2'b11, 1'b0, 1'b0, 32'h0000_0B00, 32'd0, 0, 0, 2'b00, 2'b00, 32'h7777_0000, 1'b0);

    repeat (3) @(negedge Hclk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    check("req_ready_onehot", 64'(multi_hot), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
